// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key sync/debounce, run/pause/hold FSM, 10 ms prescaler, clear/display-load generation.
// Latency: key event 3 edges after pin release, state/outputs 1 edge later; no backpressure, tick is a free-running pulse.

module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic ev
);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            cnt   <= '0;
            ev    <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            prev  <= sync2;
            ev    <= 1'b0;
            if (!sync2) begin
                if (cnt != '1)
                    cnt <= cnt + ONE;
            end else if (!prev) begin
                // release edge: only a long enough press counts
                ev  <= (cnt >= THRESH);
                cnt <= '0;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int unsigned CLK_PER_TICK    = 500000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_display_stop,
    output logic       tick_10ms,
    output logic       clear,
    output logic       disp_load,
    output logic [2:0] state,
    output logic       led_run,
    output logic       led_hold
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RUN        = 3'd1,
        PAUSE      = 3'd2,
        HOLD_RUN   = 3'd3,
        HOLD_PAUSE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(CLK_PER_TICK - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           st_q;
    state_t           st_d;
    logic             ev_reset;
    logic             ev_start;
    logic             ev_display;
    logic [CNT_W-1:0] presc;
    logic             counting;
    logic             clear_d;
    logic             disp_load_d;
    logic             led_run_d;
    logic             led_hold_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_reset (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_reset),
        .ev    (ev_reset)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_start (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_start_pause),
        .ev    (ev_start)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_display (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_display_stop),
        .ev    (ev_display)
    );

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE: begin
                // display key is meaningless before the first start
                if (ev_start)
                    st_d = RUN;
            end
            RUN: begin
                if (ev_start && ev_display) st_d = HOLD_PAUSE;
                else if (ev_start)          st_d = PAUSE;
                else if (ev_display)        st_d = HOLD_RUN;
            end
            PAUSE: begin
                if (ev_start && ev_display) st_d = HOLD_RUN;
                else if (ev_start)          st_d = RUN;
                else if (ev_display)        st_d = HOLD_PAUSE;
            end
            HOLD_RUN: begin
                if (ev_start && ev_display) st_d = PAUSE;
                else if (ev_start)          st_d = HOLD_PAUSE;
                else if (ev_display)        st_d = RUN;
            end
            HOLD_PAUSE: begin
                if (ev_start && ev_display) st_d = RUN;
                else if (ev_start)          st_d = HOLD_RUN;
                else if (ev_display)        st_d = PAUSE;
            end
            default: st_d = IDLE;
        endcase
        if (ev_reset)
            st_d = IDLE;

        clear_d     = ev_reset;
        disp_load_d = !((st_d == HOLD_RUN) || (st_d == HOLD_PAUSE));
        led_run_d   = (st_d == RUN) || (st_d == HOLD_RUN);
        led_hold_d  = (st_d == HOLD_RUN) || (st_d == HOLD_PAUSE);
    end

    // outputs are registered alongside the state so LEDs and disp_load never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= IDLE;
            clear     <= 1'b0;
            disp_load <= 1'b1;
            led_run   <= 1'b0;
            led_hold  <= 1'b0;
        end else begin
            st_q      <= st_d;
            clear     <= clear_d;
            disp_load <= disp_load_d;
            led_run   <= led_run_d;
            led_hold  <= led_hold_d;
        end
    end

    assign counting = (st_q == RUN) || (st_q == HOLD_RUN);

    // pausing freezes the partial 10 ms; only a reset discards it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (ev_reset)
            presc <= '0;
        else if (counting)
            presc <= (presc == TICK_MAX) ? '0 : presc + ONE;
    end

    assign tick_10ms = counting && (presc == TICK_MAX);
    assign state     = st_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues expected output events, a monitor pops and compares.
module tb_stopwatch_ctrl;
    localparam int CPT = 5;
    localparam int DEB = 4;
    localparam logic [2:0] K_RST   = 3'b001;
    localparam logic [2:0] K_START = 3'b010;
    localparam logic [2:0] K_DISP  = 3'b100;
    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_PAUSE = 3'd2,
                           S_HRUN = 3'd3, S_HPAUSE = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] keys;
    logic       tick_10ms, clear, disp_load, led_run, led_hold;
    logic [2:0] state;

    stopwatch_ctrl #(.CLK_PER_TICK(CPT), .DEBOUNCE_CYCLES(DEB), .CNT_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .key_reset        (keys[0]),
        .key_start_pause  (keys[1]),
        .key_display_stop (keys[2]),
        .tick_10ms        (tick_10ms),
        .clear            (clear),
        .disp_load        (disp_load),
        .state            (state),
        .led_run          (led_run),
        .led_hold         (led_hold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  st;
        logic        tick;
        logic        clr;
        logic        dl;
        logic        lr;
        logic        lh;
    } rec_t;

    rec_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         done = 1'b0;
    logic [2:0] prev_st = 3'd0;

    // expected-behaviour bookkeeping used only by the stimulus process
    logic [2:0] m_st;
    int         m_ps;
    int         sched_cyc = -1;
    logic [2:0] sched_st;
    bit         sched_clr;

    function automatic rec_t mk(input int c, input logic [2:0] s, input logic t, input logic cl);
        rec_t r;
        r.cyc  = c;
        r.st   = s;
        r.tick = t;
        r.clr  = cl;
        r.dl   = !((s == S_HRUN) || (s == S_HPAUSE));
        r.lr   = (s == S_RUN) || (s == S_HRUN);
        r.lh   = (s == S_HRUN) || (s == S_HPAUSE);
        return r;
    endfunction

    task automatic step();
        logic [2:0] old;
        bit was_cnt, tk, clr_now;
        @(posedge clk);
        cyc++;
        old     = m_st;
        was_cnt = (m_st == S_RUN) || (m_st == S_HRUN);
        clr_now = 1'b0;
        if (was_cnt)
            m_ps = (m_ps == CPT - 1) ? 0 : m_ps + 1;
        if (cyc == sched_cyc) begin
            m_st = sched_st;
            if (sched_clr) begin
                m_ps    = 0;
                clr_now = 1'b1;
            end
            sched_cyc = -1;
        end
        tk = ((m_st == S_RUN) || (m_st == S_HRUN)) && (m_ps == CPT - 1);
        if (tk || clr_now || (m_st != old))
            exp_q.push_back(mk(cyc, m_st, tk, clr_now));
        @(negedge clk);
    endtask

    // hold keys low for nlow edges; an accepted release lands in state 4 edges later
    task automatic press(input logic [2:0] mask, input int nlow, input bit acc,
                         input logic [2:0] nst, input bit clr);
        keys = keys & ~mask;
        repeat (nlow) step();
        keys = 3'b111;
        if (acc) begin
            sched_cyc = cyc + 4;
            sched_st  = nst;
            sched_clr = clr;
        end
        repeat (8) step();
    endtask

    initial begin
        rec_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                checks++;
                if (state !== 3'd0 || tick_10ms !== 1'b0 || clear !== 1'b0 ||
                    disp_load !== 1'b1 || led_run !== 1'b0 || led_hold !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_values: got state=%0d tick=%b clear=%b disp_load=%b led_run=%b led_hold=%b, expected 0 0 0 1 0 0",
                             state, tick_10ms, clear, disp_load, led_run, led_hold);
                end
                prev_st = 3'd0;
            end else if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_events: %0d expected events never seen, first expected at cyc=%0d",
                             exp_q.size(), exp_q[0].cyc);
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end else begin
                if (tick_10ms || clear || (state != prev_st)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event cyc=%0d: got state=%0d tick=%b clear=%b, expected no event",
                                 cyc, state, tick_10ms, clear);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != 32'(cyc) || e.st !== state || e.tick !== tick_10ms ||
                            e.clr !== clear || e.dl !== disp_load || e.lr !== led_run || e.lh !== led_hold) begin
                            errors++;
                            $display("FAIL event: got cyc=%0d state=%0d tick=%b clear=%b disp_load=%b led_run=%b led_hold=%b, expected cyc=%0d state=%0d tick=%b clear=%b disp_load=%b led_run=%b led_hold=%b",
                                     cyc, state, tick_10ms, clear, disp_load, led_run, led_hold,
                                     e.cyc, e.st, e.tick, e.clr, e.dl, e.lr, e.lh);
                        end
                    end
                end
                prev_st = state;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        keys  = 3'b111;
        rst_n = 1'b1;
        m_st  = S_IDLE;
        m_ps  = 0;
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // short press ignored, qualifying press starts the run
        press(K_START, 3, 1'b0, S_IDLE, 1'b0);
        press(K_START, DEB, 1'b1, S_RUN, 1'b0);
        repeat (12) step();

        // asynchronous reset mid-run with the prescaler at 3
        for (int i = 0; i < 10 && m_ps != 3; i++) step();
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_st = S_IDLE;
        m_ps = 0;
        sched_cyc = -1;
        repeat (6) step();

        // pause with prescaler frozen at 2, then resume
        press(K_START, DEB, 1'b1, S_RUN, 1'b0);
        for (int i = 0; i < 10 && m_ps != 4; i++) step();
        press(K_START, DEB, 1'b1, S_PAUSE, 1'b0);
        repeat (20) step();
        press(K_START, DEB, 1'b1, S_RUN, 1'b0);
        repeat (6) step();

        // hold toggles while ticks continue
        press(K_DISP, DEB, 1'b1, S_HRUN, 1'b0);
        repeat (12) step();
        press(K_DISP, DEB, 1'b1, S_RUN, 1'b0);

        // simultaneous start+display in RUN, then clear from HOLD_PAUSE
        press(K_START | K_DISP, DEB, 1'b1, S_HPAUSE, 1'b0);
        press(K_RST, DEB, 1'b1, S_IDLE, 1'b1);

        // display ignored in IDLE; start+display from IDLE only starts
        press(K_DISP, DEB, 1'b1, S_IDLE, 1'b0);
        press(K_START | K_DISP, DEB, 1'b1, S_RUN, 1'b0);

        // reset wins over start released in the same cycle
        press(K_RST | K_START, DEB, 1'b1, S_IDLE, 1'b1);

        // long hold: nothing happens until release
        press(K_START, 30, 1'b1, S_RUN, 1'b0);
        repeat (4) step();
        done = 1'b1;
    end
endmodule
